// File: rtl/conv_acc_sequencer.sv
// conv_acc_sequencer: the CPU fills kernel/pixel shadow buffers over a small MMIO
// window. The sequencer then streams the taps into convolution_acc, starts it,
// polls for completion (bounded by a timeout) and latches the result.
module conv_acc_sequencer #(
  parameter int N_TAPS         = 9,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DWIDTH         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [DWIDTH-1:0] cfg_din,
  output logic [DWIDTH-1:0] cfg_dout,
  output logic              acc_en,
  output logic              acc_we,
  output logic [5:0]        acc_addr,
  output logic [DWIDTH-1:0] acc_din,
  input  logic [DWIDTH-1:0] acc_dout,
  output logic              busy,
  output logic              done_irq
);
  localparam int            PW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    TAP_LAST  = 4'(N_TAPS - 1);
  localparam logic [5:0]    A_CTRL    = 6'h20;
  localparam logic [5:0]    A_STATUS  = 6'h21;
  localparam logic [5:0]    A_RESULT  = 6'h22;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_LOAD_P, S_START, S_POLL, S_READ, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] kbuf [N_TAPS];
  logic [DWIDTH-1:0] pbuf [N_TAPS];
  logic [DWIDTH-1:0] result;
  logic [3:0]        tap;
  logic [PW-1:0]     poll_cnt;
  logic              done_q, tmo_q, job_tmo;
  logic              cfg_wr, k_hit, p_hit, start_go, sts_wr, poll_expire;

  assign cfg_wr      = cfg_en & cfg_we;
  assign k_hit       = (cfg_addr[5:4] == 2'b00) & (cfg_addr[3:0] <= TAP_LAST);
  assign p_hit       = (cfg_addr[5:4] == 2'b01) & (cfg_addr[3:0] <= TAP_LAST);
  assign start_go    = cfg_wr & (cfg_addr == A_CTRL) & cfg_din[0] & ~busy;
  assign sts_wr      = cfg_wr & (cfg_addr == A_STATUS);
  // done bit has priority over the poll limit on the last poll cycle
  assign poll_expire = (state == S_POLL) & ~acc_dout[0] & (poll_cnt == POLL_LAST);
  assign done_irq    = (state == S_DONE);

  // CPU read mux, purely combinational from the address
  always_comb begin
    cfg_dout = '0;
    if (k_hit)                      cfg_dout = kbuf[cfg_addr[3:0]];
    else if (p_hit)                 cfg_dout = pbuf[cfg_addr[3:0]];
    else if (cfg_addr == A_STATUS)  cfg_dout = DWIDTH'({tmo_q, done_q, busy});
    else if (cfg_addr == A_RESULT)  cfg_dout = result;
  end

  // shadow buffers, frozen while a job is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        kbuf[i] <= '0;
        pbuf[i] <= '0;
      end
    end else if (cfg_wr && !busy) begin
      if (k_hit) kbuf[cfg_addr[3:0]] <= cfg_din;
      if (p_hit) pbuf[cfg_addr[3:0]] <= cfg_din;
    end
  end

  // state register; tap and poll counters restart on every state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tap      <= '0;
      poll_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tap      <= '0;
        poll_cnt <= '0;
      end else begin
        tap      <= tap + 4'd1;
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  // job status: START clears, CPU write-1-to-clear, completion set wins over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      job_tmo <= 1'b0;
      result  <= '0;
    end else begin
      if (start_go) begin
        busy    <= 1'b1;
        done_q  <= 1'b0;
        tmo_q   <= 1'b0;
        job_tmo <= 1'b0;
      end else if (sts_wr) begin
        if (cfg_din[1]) done_q <= 1'b0;
        if (cfg_din[2]) tmo_q  <= 1'b0;
      end
      if (poll_expire)      job_tmo <= 1'b1;
      if (state == S_READ)  result  <= acc_dout;
      if (state == S_DONE) begin
        busy <= 1'b0;
        if (job_tmo) tmo_q  <= 1'b1;
        else         done_q <= 1'b1;
      end
    end
  end

  // next state and accelerator port drive
  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_din   = '0;
    case (state)
      S_IDLE: if (start_go) state_nxt = cfg_din[1] ? S_LOAD_K : S_LOAD_P;
      S_LOAD_K: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = {2'b00, tap};
        acc_din  = kbuf[tap];
        if (tap == TAP_LAST) state_nxt = S_LOAD_P;
      end
      S_LOAD_P: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = {2'b01, tap};
        acc_din  = pbuf[tap];
        if (tap == TAP_LAST) state_nxt = S_START;
      end
      S_START: begin
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = A_CTRL;
        acc_din   = DWIDTH'(1);
        state_nxt = S_POLL;
      end
      S_POLL: begin
        acc_en   = 1'b1;
        acc_addr = A_STATUS;
        if (acc_dout[0])      state_nxt = S_READ;
        else if (poll_expire) state_nxt = S_DONE;
      end
      S_READ: begin
        acc_en    = 1'b1;
        acc_addr  = A_RESULT;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_acc_sequencer.sv
// Bench for conv_acc_sequencer: behavioural convolution_acc model on the acc port,
// shadow reference of the CPU-visible state, table vectors plus directed/random jobs.
module tb_conv_acc_sequencer;
  localparam int NT    = 9;
  localparam int TMO   = 1024;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0, cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [31:0] cfg_din = '0;
  logic [31:0] cfg_dout, acc_din, acc_dout;
  logic        acc_en, acc_we, busy, done_irq;
  logic [5:0]  acc_addr;

  conv_acc_sequencer #(.N_TAPS(NT), .TIMEOUT_CYCLES(TMO), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_din(cfg_din), .cfg_dout(cfg_dout), .acc_en(acc_en), .acc_we(acc_we),
    .acc_addr(acc_addr), .acc_din(acc_din), .acc_dout(acc_dout), .busy(busy),
    .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic we; logic [5:0] addr; logic [31:0] din; logic [31:0] exp; } vec_t;

  // ---------------- accelerator model ----------------
  wr_t         log_q[$];
  logic [31:0] mk [NT];
  logic [31:0] mp [NT];
  logic [31:0] mres = '0;
  bit          started = 1'b0;
  int          since = 0;
  int          acc_delay = NEVER;
  int          irq_cnt = 0;

  initial for (int i = 0; i < NT; i++) begin mk[i] = '0; mp[i] = '0; end

  // status done goes high acc_delay poll cycles after the start write
  assign acc_dout = (acc_addr == 6'h21) ? {31'b0, (started && since > acc_delay)} :
                    (acc_addr == 6'h22) ? mres : 32'h0;

  always @(negedge clk) begin
    if (acc_en && acc_we) begin
      log_q.push_back('{acc_addr, acc_din});
      if (acc_addr[5:4] == 2'b00 && acc_addr[3:0] < 4'(NT)) mk[acc_addr[3:0]] = acc_din;
      else if (acc_addr[5:4] == 2'b01 && acc_addr[3:0] < 4'(NT)) mp[acc_addr[3:0]] = acc_din;
      else if (acc_addr == 6'h20 && acc_din == 32'd1) begin
        started = 1'b1;
        since   = 1;
        mres    = '0;
        for (int i = 0; i < NT; i++) mres = mres + mk[i] * mp[i];
      end
    end else if (started) since = since + 1;
  end

  always @(negedge clk) if (done_irq === 1'b1) irq_cnt = irq_cnt + 1;

  // ---------------- reference state ----------------
  logic [31:0] sk [NT];
  logic [31:0] sp [NT];
  logic [31:0] acck [NT];
  logic [31:0] ref_res = '0;
  wr_t         exp_q[$];
  int          exp_lat;
  bit          exp_tmo;
  int          t0;

  initial for (int i = 0; i < NT; i++) begin sk[i] = '0; sp[i] = '0; acck[i] = '0; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_addr = a; cfg_din = d; cfg_en = 1'b1; cfg_we = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_addr = a; cfg_en = 1'b1; cfg_we = 1'b0;
    #1 d = cfg_dout;
    cfg_en = 1'b0;
  endtask

  task automatic set_k(input int i, input logic [31:0] v);
    cfg_write(6'(i), v); sk[i] = v;
  endtask

  task automatic set_p(input int i, input logic [31:0] v);
    cfg_write(6'(16 + i), v); sp[i] = v;
  endtask

  // expected accelerator traffic, latency and result of one job
  task automatic ref_job(input logic [31:0] ctrl, input int d);
    bit rl = ctrl[1];
    int poll;
    logic [31:0] s;
    exp_q.delete();
    if (rl) for (int i = 0; i < NT; i++) begin
      exp_q.push_back('{6'(i), sk[i]});
      acck[i] = sk[i];
    end
    for (int i = 0; i < NT; i++) exp_q.push_back('{6'(16 + i), sp[i]});
    exp_q.push_back('{6'h20, 32'd1});
    exp_tmo = (d > TMO);
    poll    = exp_tmo ? TMO : d;
    exp_lat = (rl ? NT : 0) + NT + 1 + poll + (exp_tmo ? 0 : 1) + 1;
    if (!exp_tmo) begin
      s = '0;
      for (int i = 0; i < NT; i++) s = s + acck[i] * sp[i];
      ref_res = s;
    end
    acc_delay = d;
    log_q.delete();
    irq_cnt = 0;
  endtask

  task automatic start_job(input logic [31:0] ctrl);
    cfg_write(6'h20, ctrl);
    t0 = cyc;
  endtask

  // latency counts the START write edge as cycle 1
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done_irq === 1'b1) begin lat = cyc - t0 + 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic post_check(input string tag, input int lat, input logic [31:0] exp_sts);
    logic [31:0] v;
    int errs;
    check({tag, " latency"}, lat, exp_lat);
    cfg_read(6'h21, v); check({tag, " status"}, v, exp_sts);
    cfg_read(6'h22, v); check({tag, " result"}, v, ref_res);
    errs = (log_q.size() == exp_q.size()) ? 0 : 1;
    if (errs == 0) foreach (exp_q[i])
      if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) errs++;
    check({tag, " acc writes"}, errs, 0);
    check({tag, " irq pulses"}, irq_cnt, 1);
  endtask

  task automatic run_job(input string tag, input logic [31:0] ctrl, input int d);
    int lat;
    ref_job(ctrl, d);
    start_job(ctrl);
    wait_done(lat);
    @(negedge clk);
    check({tag, " irq width"}, done_irq, 1'b0);
    post_check(tag, lat, exp_tmo ? 32'h4 : 32'h2);
  endtask

  vec_t vt[$];

  initial begin
    logic [31:0] v;
    int lat, errs;
    bit found;

    vt.push_back('{1'b1, 6'h00, 32'h11111111, 32'h0});
    vt.push_back('{1'b1, 6'h08, 32'hDEADBEEF, 32'h0});
    vt.push_back('{1'b1, 6'h10, 32'h00000005, 32'h0});
    vt.push_back('{1'b1, 6'h18, 32'hCAFE0000, 32'h0});
    vt.push_back('{1'b1, 6'h09, 32'h00001234, 32'h0});
    vt.push_back('{1'b1, 6'h30, 32'h00000007, 32'h0});
    vt.push_back('{1'b1, 6'h20, 32'h00000002, 32'h0});
    vt.push_back('{1'b0, 6'h00, 32'h0, 32'h11111111});
    vt.push_back('{1'b0, 6'h08, 32'h0, 32'hDEADBEEF});
    vt.push_back('{1'b0, 6'h10, 32'h0, 32'h00000005});
    vt.push_back('{1'b0, 6'h18, 32'h0, 32'hCAFE0000});
    vt.push_back('{1'b0, 6'h09, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h19, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h30, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h3F, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h20, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h21, 32'h0, 32'h0});
    vt.push_back('{1'b0, 6'h22, 32'h0, 32'h0});

    // reset state
    repeat (3) @(negedge clk);
    check("rst acc_en", acc_en, 1'b0);
    check("rst acc_we", acc_we, 1'b0);
    check("rst acc_addr", acc_addr, 6'h0);
    check("rst acc_din", acc_din, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst done_irq", done_irq, 1'b0);
    rst = 1'b0;

    // register map vectors
    foreach (vt[i]) begin
      if (vt[i].we) cfg_write(vt[i].addr, vt[i].din);
      else begin
        cfg_read(vt[i].addr, v);
        check($sformatf("vec%0d rd 0x%0h", i, vt[i].addr), v, vt[i].exp);
      end
    end

    // full job with kernel reload
    for (int i = 0; i < NT; i++) begin set_k(i, 32'(i + 1)); set_p(i, 32'd2); end
    run_job("job reload", 32'h3, 3);
    // kernel buffer changed but not reloaded: accelerator keeps the old kernel
    set_k(0, 32'd100);
    run_job("job noreload", 32'h1, 3);
    // timeout path, then write-1-to-clear
    run_job("timeout", 32'h1, NEVER);
    cfg_write(6'h21, 32'h6);
    cfg_read(6'h21, v); check("tmo clear", v, 32'h0);
    // done seen on the very last allowed poll cycle, and one cycle too late
    run_job("poll last", 32'h1, TMO);
    run_job("poll late", 32'h1, TMO + 1);

    // writes while busy are ignored; clear in the DONE cycle loses to the set
    ref_job(32'h3, 5);
    start_job(32'h3);
    repeat (3) @(negedge clk);
    cfg_write(6'h00, 32'hFF);
    cfg_write(6'h20, 32'h3);
    wait_done(lat);
    cfg_addr = 6'h21; cfg_din = 32'h2; cfg_en = 1'b1; cfg_we = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0; cfg_we = 1'b0;
    check("busy irq width", done_irq, 1'b0);
    post_check("busy", lat, 32'h2);
    cfg_read(6'h00, v); check("busy kbuf0", v, sk[0]);
    cfg_write(6'h21, 32'h6);
    cfg_read(6'h21, v); check("done clear", v, 32'h0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 1) == 1) set_k(i, $urandom);
        if ($urandom_range(0, 1) == 1) set_p(i, $urandom);
      end
      run_job($sformatf("rnd%0d", j), 32'h1 | (32'($urandom_range(0, 1)) << 1),
              int'($urandom_range(1, 12)));
    end

    // reset in the middle of LOAD_P tap 4
    ref_job(32'h3, 3);
    start_job(32'h3);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (acc_en === 1'b1 && acc_addr == 6'h14) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rst reach tap4", found, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst acc_en", acc_en, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst done_irq", done_irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    irq_cnt = 0;
    cfg_read(6'h21, v); check("midrst status", v, 32'h0);
    cfg_read(6'h22, v); check("midrst result", v, 32'h0);
    errs = 0;
    for (int i = 0; i < NT; i++) begin
      cfg_read(6'(i), v);      if (v !== 32'h0) errs++;
      cfg_read(6'(16 + i), v); if (v !== 32'h0) errs++;
    end
    check("midrst bufs", errs, 0);
    repeat (30) @(negedge clk);
    check("midrst no acc", log_q.size(), 0);
    check("midrst no irq", irq_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
